// File: rtl/i2c_bus_frontend_pkg.sv
// Shared definitions for the I2C bus front end.
// FSM state encodings and the ACK slot index are also used by i2c_periph.
package i2c_bus_frontend_pkg;

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned BIT_IDX_W = 4;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [3:0] ACK_SLOT      = 4'd8;
  localparam logic [3:0] LAST_DATA_BIT = 4'd7;

  // Combinational bus events derived from the filtered lines.
  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
  } bus_events_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Pad synchroniser plus optional majority-free persistence filter for one line.
// Macro I2C_FRONTEND_GLITCH_FILTER_EN enables the filter; otherwise the
// synchronised level is passed straight through.
// Ports:
//   clk, rst_n  system clock, async active-low reset (line idles at 1)
//   pad         raw pad level
//   filtered    synchronised (and optionally filtered) level
module i2c_line_filter #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER_DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic filtered
);

  // Elaboration-time parameter range checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("i2c_line_filter: SYNC_STAGES must be at least 2");
  end
  if ((FILTER_DEPTH < 1) || (FILTER_DEPTH > 15)) begin : g_bad_depth
    $error("i2c_line_filter: FILTER_DEPTH must be in 1..15");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  // Synchroniser chain, reset to the idle-high bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef I2C_FRONTEND_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_DEPTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             level_q;

  // Accept a new level only after FILTER_DEPTH consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else if (synced != level_q) begin
      if (cnt_q == CNT_W'(FILTER_DEPTH - 1)) begin
        level_q <= synced;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign filtered = level_q;
`else
  assign filtered = synced;
`endif

endmodule

// File: rtl/i2c_bus_frontend.sv
// Oversampling SCL/SDA front end for i2c_periph.
// Synchronises/deglitches the pads, detects SCL edges, START and STOP,
// tracks the bit position, assembles received bytes and gates the SDA
// pull-low request so SDA only changes while SCL is low.
// Build option: I2C_FRONTEND_GLITCH_FILTER_EN enables the glitch filter.
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   scl_in, sda_in raw pads
//   sda_drive_low  request to pull SDA low
//   sda_oe         pad output enable (drives 0)
//   scl_rise/scl_fall/start_det/stop_det  one-cycle strobes
//   bus_busy       START seen, STOP not yet
//   bit_index      0..7 data bit, 8 ACK slot
//   rx_byte/rx_valid  last received byte and its update strobe
module i2c_bus_frontend
  import i2c_bus_frontend_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scl_in,
  input  logic                 sda_in,
  input  logic                 sda_drive_low,
  output logic                 sda_oe,
  output logic                 scl_rise,
  output logic                 scl_fall,
  output logic                 start_det,
  output logic                 stop_det,
  output logic                 bus_busy,
  output logic [BIT_IDX_W-1:0] bit_index,
  output logic [BYTE_W-1:0]    rx_byte,
  output logic                 rx_valid
);

  logic scl_f;
  logic sda_f;
  logic scl_q;
  logic sda_q;

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_DEPTH(FILTER_DEPTH)
  ) u_scl_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .pad     (scl_in),
    .filtered(scl_f)
  );

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_DEPTH(FILTER_DEPTH)
  ) u_sda_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .pad     (sda_in),
    .filtered(sda_f)
  );

  // Previous filtered levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // START/STOP need SCL high in both samples, so a same-cycle SCL change
  // suppresses them and only the SCL edge is reported.
  bus_events_t ev_c;
  always_comb begin
    ev_c           = '0;
    ev_c.scl_rise  = scl_f & ~scl_q;
    ev_c.scl_fall  = ~scl_f & scl_q;
    ev_c.start_det = scl_f & scl_q & sda_q & ~sda_f;
    ev_c.stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  end

  logic [STATE_W-1:0]   state_q;
  logic [STATE_W-1:0]   state_d;
  logic [BIT_IDX_W-1:0] bit_index_d;
  logic [BYTE_W-2:0]    shift_q;
  logic [BYTE_W-2:0]    shift_d;
  logic                 bit_seen_q;
  logic                 bit_seen_d;
  logic [BYTE_W-1:0]    rx_byte_d;
  logic                 rx_valid_d;
  logic                 bus_busy_d;
  logic                 sda_oe_d;

  // Next-state logic. The shift register keeps the first seven bits; the
  // eighth is taken straight from SDA into rx_byte on the final rise.
  // bit_seen_q gates bit_index so the SCL fall that closes a START (no
  // preceding rise in this bit) does not count as a bit.
  always_comb begin
    state_d     = state_q;
    bit_index_d = bit_index;
    shift_d     = shift_q;
    bit_seen_d  = bit_seen_q;
    rx_byte_d   = rx_byte;
    rx_valid_d  = 1'b0;
    bus_busy_d  = bus_busy;
    sda_oe_d    = sda_oe;

    if (ev_c.start_det) begin
      state_d     = ST_DATA;
      bit_index_d = '0;
      shift_d     = '0;
      bit_seen_d  = 1'b0;
      bus_busy_d  = 1'b1;
    end else if (ev_c.stop_det) begin
      state_d     = ST_IDLE;
      bit_index_d = '0;
      shift_d     = '0;
      bit_seen_d  = 1'b0;
      bus_busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_index_d = '0;
        end
        ST_DATA: begin
          if (ev_c.scl_rise) begin
            bit_seen_d = 1'b1;
            shift_d    = {shift_q[BYTE_W-3:0], sda_f};
            if (bit_index == LAST_DATA_BIT) begin
              rx_byte_d  = {shift_q, sda_f};
              rx_valid_d = 1'b1;
            end
          end else if (ev_c.scl_fall && bit_seen_q) begin
            bit_seen_d = 1'b0;
            if (bit_index == LAST_DATA_BIT) begin
              state_d     = ST_ACK;
              bit_index_d = ACK_SLOT;
            end else begin
              bit_index_d = bit_index + BIT_IDX_W'(1);
            end
          end
        end
        ST_ACK: begin
          if (ev_c.scl_rise) begin
            bit_seen_d = 1'b1;
          end else if (ev_c.scl_fall && bit_seen_q) begin
            state_d     = ST_DATA;
            bit_index_d = '0;
            bit_seen_d  = 1'b0;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          bit_index_d = '0;
          bit_seen_d  = 1'b0;
          bus_busy_d  = 1'b0;
        end
      endcase
    end

    // SDA may only change while SCL is low; START/STOP/IDLE release it at once.
    if (ev_c.start_det || ev_c.stop_det || (state_q == ST_IDLE)) begin
      sda_oe_d = 1'b0;
    end else if (!scl_f) begin
      sda_oe_d = sda_drive_low & bus_busy;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_index  <= '0;
      shift_q    <= '0;
      bit_seen_q <= 1'b0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      bus_busy   <= 1'b0;
      sda_oe     <= 1'b0;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_index  <= bit_index_d;
      shift_q    <= shift_d;
      bit_seen_q <= bit_seen_d;
      rx_byte    <= rx_byte_d;
      rx_valid   <= rx_valid_d;
      bus_busy   <= bus_busy_d;
      sda_oe     <= sda_oe_d;
      scl_rise   <= ev_c.scl_rise;
      scl_fall   <= ev_c.scl_fall;
      start_det  <= ev_c.start_det;
      stop_det   <= ev_c.stop_det;
    end
  end

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed testbench for i2c_bus_frontend: reset, byte reception, glitch
// handling, repeated START, SDA output gating, STOP and simultaneous edges.
module tb_i2c_bus_frontend;

  localparam int unsigned SYNC_STAGES  = 2;
  localparam int unsigned FILTER_DEPTH = 3;
  localparam int unsigned HOLD         = 12;
`ifdef I2C_FRONTEND_GLITCH_FILTER_EN
  localparam int unsigned GLITCH_EDGES = 0;
`else
  localparam int unsigned GLITCH_EDGES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_in;
  logic       sda_in;
  logic       sda_drive_low;
  logic       sda_oe;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       bus_busy;
  logic [3:0] bit_index;
  logic [7:0] rx_byte;
  logic       rx_valid;

  int n_checks = 0;
  int n_errors = 0;

  int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_rx = 0, n_misalign = 0;
  int s_rise, s_fall, s_start, s_stop, s_rx;

  always #5 clk = ~clk;

  i2c_bus_frontend #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_DEPTH(FILTER_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_in       (scl_in),
    .sda_in       (sda_in),
    .sda_drive_low(sda_drive_low),
    .sda_oe       (sda_oe),
    .scl_rise     (scl_rise),
    .scl_fall     (scl_fall),
    .start_det    (start_det),
    .stop_det     (stop_det),
    .bus_busy     (bus_busy),
    .bit_index    (bit_index),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid)
  );

  // Pulse counters; each registered strobe is seen once per posedge it is high.
  always @(posedge clk) begin
    if (scl_rise)  n_rise++;
    if (scl_fall)  n_fall++;
    if (start_det) n_start++;
    if (stop_det)  n_stop++;
    if (rx_valid) begin
      n_rx++;
      if (!scl_rise) n_misalign++;
    end
  end

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_rise  = n_rise;
    s_fall  = n_fall;
    s_start = n_start;
    s_stop  = n_stop;
    s_rx    = n_rx;
  endtask

  task automatic drive(input logic scl_v, input logic sda_v);
    @(negedge clk);
    scl_in = scl_v;
    sda_in = sda_v;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    drive(1'b0, b);
    drive(1'b1, b);
    drive(1'b0, b);
  endtask

  task automatic do_start();
    drive(scl_in, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic do_stop();
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    rst_n         = 1'b0;
    scl_in        = 1'b1;
    sda_in        = 1'b1;
    sda_drive_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (HOLD) @(negedge clk);

    // Reset state
    chk("rst_bit_index", bit_index, 0);
    chk("rst_bus_busy", bus_busy, 0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_pulses", {scl_rise, scl_fall, start_det, stop_det, rx_valid}, 0);

    // Byte 0xAA
    snap();
    do_start();
    chk("aa_start_cnt", n_start - s_start, 1);
    chk("aa_busy", bus_busy, 1);
    chk("aa_bit_index_0", bit_index, 0);
    b = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      send_bit(b[7-i]);
      chk($sformatf("aa_bit_index_%0d", i + 1), bit_index, i + 1);
    end
    chk("aa_rx_cnt", n_rx - s_rx, 1);
    chk("aa_rx_byte", rx_byte, 8'hAA);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("aa_ack_to_data", bit_index, 0);
    snap();
    do_stop();
    chk("aa_stop_cnt", n_stop - s_stop, 1);
    chk("aa_stop_busy", bus_busy, 0);

    // Asynchronous reset mid-byte
    do_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("mid_bit_index", bit_index, 5);
    @(negedge clk);
    sda_drive_low = 1'b1;
    repeat (HOLD) @(negedge clk);
    chk("mid_sda_oe", sda_oe, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_bit_index", bit_index, 0);
    chk("arst_bus_busy", bus_busy, 0);
    chk("arst_rx_byte", rx_byte, 8'h00);
    chk("arst_sda_oe", sda_oe, 0);
    scl_in        = 1'b1;
    sda_in        = 1'b1;
    sda_drive_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (HOLD) @(negedge clk);

    // Two-clock SCL low glitch
    snap();
    @(negedge clk);
    scl_in = 1'b0;
    repeat (2) @(negedge clk);
    scl_in = 1'b1;
    repeat (HOLD) @(negedge clk);
    chk("glitch_fall", n_fall - s_fall, GLITCH_EDGES);
    chk("glitch_rise", n_rise - s_rise, GLITCH_EDGES);

    // Repeated START after three bits, then byte 0x5C
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("rs_bit_index_3", bit_index, 3);
    snap();
    do_start();
    chk("rs_start_cnt", n_start - s_start, 1);
    chk("rs_bit_index_0", bit_index, 0);
    chk("rs_no_rx", n_rx - s_rx, 0);
    b = 8'h5C;
    for (int i = 0; i < 8; i++) send_bit(b[7-i]);
    chk("rs_rx_cnt", n_rx - s_rx, 1);
    chk("rs_rx_byte", rx_byte, 8'h5C);
    chk("rs_ack_slot", bit_index, 8);

    // SDA output gating and STOP release
    drive(1'b1, 1'b0);
    @(negedge clk);
    sda_drive_low = 1'b1;
    repeat (HOLD) @(negedge clk);
    chk("oe_wait_scl_low", sda_oe, 0);
    drive(1'b0, 1'b0);
    chk("oe_load_scl_low", sda_oe, 1);
    drive(1'b1, 1'b0);
    @(negedge clk);
    sda_drive_low = 1'b0;
    repeat (HOLD) @(negedge clk);
    chk("oe_hold_scl_high", sda_oe, 1);
    drive(1'b0, 1'b0);
    chk("oe_release_scl_low", sda_oe, 0);
    @(negedge clk);
    sda_drive_low = 1'b1;
    repeat (HOLD) @(negedge clk);
    chk("oe_reload", sda_oe, 1);
    snap();
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    chk("stop_cnt", n_stop - s_stop, 1);
    chk("stop_busy", bus_busy, 0);
    chk("stop_sda_oe", sda_oe, 0);
    chk("stop_bit_index", bit_index, 0);
    sda_drive_low = 1'b0;

    // Simultaneous SCL and SDA changes
    snap();
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    chk("sim_fall", n_fall - s_fall, 1);
    chk("sim_rise", n_rise - s_rise, 1);
    chk("sim_no_start", n_start - s_start, 0);
    chk("sim_no_stop", n_stop - s_stop, 0);
    chk("sim_busy", bus_busy, 0);

    chk("rx_valid_with_rise", n_misalign, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
